// File: rtl/mem_copy_pkg.sv
// Shared definitions for the block-copy engine.
//   state_t          : copy FSM states
//   AW_DEF / DW_DEF  : default address and data widths
//   CYCLES_PER_WORD  : RD + CAP + WR, one memory word every three cycles
package mem_copy_pkg;

  localparam int AW_DEF          = 16;
  localparam int DW_DEF          = 16;
  localparam int CYCLES_PER_WORD = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4,
    ABT  = 3'd5
  } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Memory-port bundle between the copy engine (master) and the data memory
// (slave).
//   BaseAdd   : word address
//   ReadMem   : read enable, data returns on MemRdData one cycle later
//   WriteMem  : write enable
//   MemWrData : write data
//   MemRdData : read data from memory
interface mem_copy_engine_if
  import mem_copy_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic [AW-1:0] BaseAdd;
  logic          ReadMem;
  logic          WriteMem;
  logic [DW-1:0] MemWrData;
  logic [DW-1:0] MemRdData;

  modport master (
    output BaseAdd,
    output ReadMem,
    output WriteMem,
    output MemWrData,
    input  MemRdData
  );

  modport slave (
    input  BaseAdd,
    input  ReadMem,
    input  WriteMem,
    input  MemWrData,
    output MemRdData
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Block-copy DMA master for the 16-bit data memory.
// Copies Length words from SrcAdd upward to DstAdd upward, one word per
// RD/CAP/WR triple, through the memory's single port.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   Start, Abort      : copy request (IDLE only) / terminate running copy
//   SrcAdd, DstAdd    : first source / destination word address
//   Length            : number of words to copy
//   Busy              : high in RD, CAP, WR
//   Done, Aborted     : one-cycle completion / abort pulses
//   Count             : words written in the current or last copy
//   mem               : memory port (master side)
// Every output is a flop; nothing on the outputs depends combinationally
// on any input.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Start,
  input  logic                Abort,
  input  logic [AW-1:0]       SrcAdd,
  input  logic [AW-1:0]       DstAdd,
  input  logic [15:0]         Length,
  output logic                Busy,
  output logic                Done,
  output logic                Aborted,
  output logic [15:0]         Count,
  mem_copy_engine_if.master   mem
);

  state_t        state_reg;
  logic [AW-1:0] src_reg;
  logic [AW-1:0] dst_reg;
  logic [15:0]   len_reg;
  logic [15:0]   count_reg;
  logic [15:0]   count_next;
  logic          busy_reg;
  logic          done_reg;
  logic          aborted_reg;
  logic [AW-1:0] base_add_reg;
  logic          read_reg;
  logic          write_reg;
  // Word buffer: loaded from read data in CAP and presented as write data
  // in WR; cleared outside WR so the bus idles at zero.
  logic [DW-1:0] data_buf_reg;

  // Count after the write of the current WR cycle.
  assign count_next = count_reg + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      src_reg      <= '0;
      dst_reg      <= '0;
      len_reg      <= '0;
      count_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      aborted_reg  <= 1'b0;
      base_add_reg <= '0;
      read_reg     <= 1'b0;
      write_reg    <= 1'b0;
      data_buf_reg <= '0;
    end else begin
      // Pulses and memory strobes last exactly one cycle unless re-armed.
      done_reg     <= 1'b0;
      aborted_reg  <= 1'b0;
      read_reg     <= 1'b0;
      write_reg    <= 1'b0;
      base_add_reg <= '0;

      case (state_reg)
        IDLE: begin
          if (Start) begin
            src_reg   <= SrcAdd;
            dst_reg   <= DstAdd;
            len_reg   <= Length;
            count_reg <= '0;
            if (Length != 16'd0) begin
              state_reg    <= RD;
              busy_reg     <= 1'b1;
              read_reg     <= 1'b1;
              base_add_reg <= SrcAdd;
            end else begin
              state_reg <= FIN;
              done_reg  <= 1'b1;
            end
          end
        end

        RD: begin
          if (Abort) begin
            state_reg   <= ABT;
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b1;
          end else begin
            state_reg <= CAP;
          end
        end

        CAP: begin
          if (Abort) begin
            state_reg   <= ABT;
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b1;
          end else begin
            // Read data is valid now, one cycle after the RD strobe.
            state_reg    <= WR;
            data_buf_reg <= mem.MemRdData;
            write_reg    <= 1'b1;
            base_add_reg <= dst_reg + AW'(count_reg);
          end
        end

        WR: begin
          // The write on the bus this cycle always completes, even when
          // aborting, so it is always counted.
          count_reg    <= count_next;
          data_buf_reg <= '0;
          if (Abort) begin
            state_reg   <= ABT;
            busy_reg    <= 1'b0;
            aborted_reg <= 1'b1;
          end else if (count_next == len_reg) begin
            state_reg <= FIN;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            state_reg    <= RD;
            read_reg     <= 1'b1;
            base_add_reg <= src_reg + AW'(count_next);
          end
        end

        FIN: state_reg <= IDLE;

        ABT: state_reg <= IDLE;

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy          = busy_reg;
  assign Done          = done_reg;
  assign Aborted       = aborted_reg;
  assign Count         = count_reg;
  assign mem.BaseAdd   = base_add_reg;
  assign mem.ReadMem   = read_reg;
  assign mem.WriteMem  = write_reg;
  assign mem.MemWrData = data_buf_reg;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: directed scenarios plus random
// copies, compared cycle by cycle against a forward-copy reference model.
module tb_mem_copy_engine;
  import mem_copy_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [15:0] SrcAdd = '0;
  logic [15:0] DstAdd = '0;
  logic [15:0] Length = '0;
  logic        Busy;
  logic        Done;
  logic        Aborted;
  logic [15:0] Count;

  int checks = 0;
  int failures = 0;

  mem_copy_engine_if #(.AW(16), .DW(16)) bus ();

  mem_copy_engine #(.AW(16), .DW(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .Abort   (Abort),
    .SrcAdd  (SrcAdd),
    .DstAdd  (DstAdd),
    .Length  (Length),
    .Busy    (Busy),
    .Done    (Done),
    .Aborted (Aborted),
    .Count   (Count),
    .mem     (bus)
  );

  always #5 clk = ~clk;

  // Memory model: one port, registered read.
  logic [15:0] mem_arr   [0:65535];
  logic [15:0] model_mem [0:65535];
  logic        load_req = 1'b0;
  logic [15:0] rd_q = '0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 65536; i++) mem_arr[i] <= model_mem[i];
    end else begin
      if (bus.WriteMem) mem_arr[bus.BaseAdd] <= bus.MemWrData;
      if (bus.ReadMem) rd_q <= mem_arr[bus.BaseAdd];
    end
  end
  assign bus.MemRdData = rd_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one copy starting at a falling edge. abort_cyc/reset_cyc (0 = none)
  // name the cycle, counted from the accepting edge, in which Abort/reset is
  // held high. noise pulses Start with junk arguments while busy.
  task automatic run_copy(input string name, input logic [15:0] src, input logic [15:0] dst,
                          input int len, input int abort_cyc, input int reset_cyc, input bit noise);
    int end_cyc, nw, k, ph, mism;
    logic [15:0] exp_data[$];
    logic [4:0]  exp_flags;
    logic [15:0] exp_count, exp_base, exp_wdata;
    logic [15:0] a;
    bit          strobe;

    end_cyc = (abort_cyc > 0) ? abort_cyc : (reset_cyc > 0) ? reset_cyc : CYCLES_PER_WORD * len;
    nw = end_cyc / CYCLES_PER_WORD;
    // Reference: ascending word-by-word copy; each word is read after all
    // earlier words have been written.
    for (int w = 0; w < nw; w++) begin
      a = src + 16'(w);
      exp_data.push_back(model_mem[a]);
      a = dst + 16'(w);
      model_mem[a] = exp_data[w];
    end

    Start = 1'b1; SrcAdd = src; DstAdd = dst; Length = 16'(len);
    @(posedge clk);
    for (int c = 1; c <= end_cyc + 2; c++) begin
      @(negedge clk);
      exp_base = '0; exp_wdata = '0; strobe = 1'b0;
      if (c <= end_cyc) begin
        k  = (c - 1) / CYCLES_PER_WORD;
        ph = (c - 1) % CYCLES_PER_WORD;
        // {Busy, Done, Aborted, ReadMem, WriteMem}
        exp_flags = {1'b1, 1'b0, 1'b0, ph == 0, ph == 2};
        exp_count = 16'(k);
        if (ph == 0) begin exp_base = src + 16'(k); strobe = 1'b1; end
        if (ph == 2) begin exp_base = dst + 16'(k); exp_wdata = exp_data[k]; strobe = 1'b1; end
      end else if (c == end_cyc + 1) begin
        if (reset_cyc > 0)      begin exp_flags = 5'b00000; exp_count = '0; end
        else if (abort_cyc > 0) begin exp_flags = 5'b00100; exp_count = 16'(nw); end
        else                    begin exp_flags = 5'b01000; exp_count = 16'(nw); end
      end else begin
        exp_flags = 5'b00000;
        exp_count = (reset_cyc > 0) ? 16'd0 : 16'(nw);
      end
      check($sformatf("%s c%0d flags", name, c),
            {27'd0, Busy, Done, Aborted, bus.ReadMem, bus.WriteMem}, {27'd0, exp_flags});
      check($sformatf("%s c%0d count", name, c), {16'd0, Count}, {16'd0, exp_count});
      if (strobe) check($sformatf("%s c%0d addr", name, c), {16'd0, bus.BaseAdd}, {16'd0, exp_base});
      if (exp_flags[0]) check($sformatf("%s c%0d wdata", name, c), {16'd0, bus.MemWrData}, {16'd0, exp_wdata});
      if (reset_cyc > 0 && c == end_cyc + 1) begin
        check($sformatf("%s c%0d addr_rst", name, c), {16'd0, bus.BaseAdd}, 32'd0);
        check($sformatf("%s c%0d wdata_rst", name, c), {16'd0, bus.MemWrData}, 32'd0);
      end
      // Inputs for this cycle
      Start  = noise && (c < end_cyc);
      SrcAdd = noise ? 16'($urandom) : src;
      DstAdd = noise ? 16'($urandom) : dst;
      Length = noise ? 16'($urandom_range(1, 9)) : 16'(len);
      Abort  = (c == abort_cyc);
      reset  = (c == reset_cyc);
    end
    Start = 1'b0; Abort = 1'b0; reset = 1'b0;

    mism = 0;
    for (int i = 0; i < 65536; i++) if (mem_arr[i] !== model_mem[i]) mism++;
    check($sformatf("%s mem_image", name), mism, 0);
    $display("copy %-10s src=%04h dst=%04h len=%0d words_written=%0d mem_diffs=%0d",
             name, src, dst, len, nw, mism);
  endtask

  initial begin
    logic [15:0] rs, rd;
    int rl, ra;

    for (int i = 0; i < 65536; i++) model_mem[i] = 16'($urandom);
    model_mem[8]  = 16'hFFFF;
    model_mem[9]  = 16'h000F;
    model_mem[10] = 16'h00FF;
    model_mem[11] = 16'h0FFF;
    load_req = 1'b1;
    Abort = 1'b1;                 // also ignored while in reset/IDLE
    repeat (2) @(posedge clk);
    @(negedge clk);
    load_req = 1'b0;
    check("reset flags", {27'd0, Busy, Done, Aborted, bus.ReadMem, bus.WriteMem}, 32'd0);
    check("reset count", {16'd0, Count}, 32'd0);
    check("reset addr", {16'd0, bus.BaseAdd}, 32'd0);
    check("reset wdata", {16'd0, bus.MemWrData}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_abort flags", {27'd0, Busy, Done, Aborted, bus.ReadMem, bus.WriteMem}, 32'd0);
    Abort = 1'b0;

    run_copy("basic",   16'd8,     16'd100,   4, 0, 0, 1'b0);
    check("basic word100", {16'd0, mem_arr[100]}, 32'h0000FFFF);
    check("basic word103", {16'd0, mem_arr[103]}, 32'h00000FFF);
    run_copy("zero",    16'd40,    16'd300,   0, 0, 0, 1'b0);
    run_copy("wrap",    16'hFFFE,  16'h0200,  3, 0, 0, 1'b0);
    run_copy("abort",   16'd20,    16'd400,   4, 6, 0, 1'b0);
    run_copy("rst_mid", 16'd30,    16'd500,   4, 0, 8, 1'b0);
    run_copy("after_rst", 16'd30,  16'd600,   4, 0, 0, 1'b0);
    run_copy("overlap", 16'd10,    16'd8,     4, 0, 0, 1'b1);
    run_copy("fwd_ovl", 16'd50,    16'd52,    5, 0, 0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      rs = 16'($urandom);
      rd = rs + 16'($urandom_range(0, 40)) - 16'd20;
      rl = $urandom_range(1, 12);
      ra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3 * rl) : 0;
      run_copy($sformatf("rand%0d", t), rs, rd, rl, ra, 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Block-copy initiator for the 16-bit data memory: on a start strobe it reads `Length` consecutive words from a source region and writes them to a destination region, one word at a time, through the memory's single read/write port. It drives the memory-side control signals:

- `BaseAdd`, `ReadMem`, `WriteMem`, and the write data.
- It consumes the memory's read data.

It sits beside the CPU datapath as a simple DMA master, and the memory port must be granted to it exclusively while `Busy` is high.

## Interface
Parameters:
- `AW`, 16: address width (word addresses).
- `DW`, 16: data word width.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `Start` in 1: copy request; sampled only in IDLE.
- `Abort` in 1: terminates a running copy.
- `SrcAdd` in AW: first source word address; captured on accepted `Start`.
- `DstAdd` in AW: first destination word address; captured on accepted `Start`.
- `Length` in 16: word count; captured on accepted `Start`.
- `Busy` out 1: copy in progress.
- `Done` out 1: one-cycle pulse at normal completion.
- `Aborted` out 1: one-cycle pulse after an abort.
- `Count` out 16: words written so far in the current or last copy.
- `BaseAdd` out AW: memory address.
- `ReadMem` out 1: memory read enable.
- `WriteMem` out 1: memory write enable.
- `MemWrData` out DW: data to memory.
- `MemRdData` in DW: data from memory; valid in the cycle after a cycle with `ReadMem`=1.

## Operation
- **State machine:** IDLE, RD, CAP, WR, FIN, ABT.
- **Outputs:** all outputs are registered (Moore); no combinational path from any input to any output.
- **IDLE:** all memory controls are 0.
    - `Start`=1 with `Length`≠0: latch src, dst and len, clear `Count`, go to RD.
    - `Start`=1 with `Length`=0: go to FIN with no memory access.
- **RD:** `ReadMem`=1, `BaseAdd`=src+`Count`. Go to CAP.
- **CAP:** `ReadMem`=0; `MemRdData` is captured into the word buffer. Go to WR.
- **WR:** `WriteMem`=1, `BaseAdd`=dst+`Count`, `MemWrData`=buffer. `Count` increments at the end of WR.
    - If the new `Count` equals len, go to FIN; else go to RD.
- **FIN:** `Done`=1, `Busy`=0. Go to IDLE.
- **ABT:** `Aborted`=1, `Busy`=0. Go to IDLE.
- **Abort:** when `Abort`=1 in RD, CAP or WR, the next state is ABT.
    - If this happens in WR, the write in that cycle still completes and is counted.
    - `Abort` in IDLE, FIN or ABT is ignored.
- **Busy:** `Busy`=1 in RD, CAP and WR only.
- **Start while not IDLE:** ignored; no queuing.
- **Address arithmetic:** modulo 2^AW. Addresses wrap from 0xFFFF to 0x0000 silently.
- **Copy order:** always ascending.
    - Overlapping regions with dst≤src produce a correct copy.
    - With dst>src overlapping, the result is the defined forward-copy result; no detection is performed.
- **Count:** holds its final value in IDLE until the next accepted `Start`.

## Timing
- **Reset values:** all outputs are 0 after any reset edge, and the state is IDLE.
    - This applies to `Busy`, `Done`, `Aborted`, `Count`, `BaseAdd`, `ReadMem`, `WriteMem` and `MemWrData`.
- **Reset mid-copy:** takes effect at that edge with no further memory access. Words already written stay in memory; `Done` and `Aborted` are not pulsed.
- **Start accepted at edge E0:** word k occupies cycles 3k+1 (RD), 3k+2 (CAP) and 3k+3 (WR). `Done` is high in cycle 3L+1.
- **Idle gap:** `Start` may be re-accepted in cycle 3L+2.
- **Length=0:** `Done` in cycle 1.
- **Memory port:** `ReadMem` and `WriteMem` are never both 1. Each is high for exactly one cycle per word.

## Structure
- **Shared package `mem_copy_pkg`:**
    - State enum: IDLE, RD, CAP, WR, FIN, ABT.
    - `AW`/`DW` defaults.
    - The 3-cycles-per-word constant, for use by benches.
- **Module:** single module, no sub-module. The address adders and the word buffer are inline.

## Test plan
- **Basic copy:** memory preloaded with 8:FFFF, 9:000F, 10:00FF, 11:0FFF; `Start` with `SrcAdd`=8, `DstAdd`=100, `Length`=4.
    - Required: addresses 100–103 hold FFFF, 000F, 00FF, 0FFF.
    - `Done` pulses in cycle 13; `Count`=4; `Busy` is high for cycles 1–12.
- **Zero length:** `Length`=0.
    - Required: `Done` in cycle 1; `ReadMem`/`WriteMem` never asserted; memory unchanged.
- **Wrap-around:** `SrcAdd`=FFFE, `DstAdd`=0x0200, `Length`=3.
    - Required: reads from FFFE, FFFF and 0000 land at 0x200–0x202.
- **Abort:** `Abort` asserted in the WR cycle of word 1 of a `Length`=4 copy.
    - Required: 2 words written; `Count`=2; `Aborted` pulses once; `Done` never asserted.
- **Reset mid-copy:** `reset` in the CAP cycle of word 2.
    - Required: all outputs 0 the next cycle; only words 0 and 1 written.
    - A following `Start` copies correctly.
- **Overlap:** `SrcAdd`=10, `DstAdd`=8, `Length`=4 over known data.
    - Required: a correct descending-overlap copy.
    - `Start` pulses during `Busy` are ignored.
